// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter block and its
// return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_TARGET = 3'd2,
    SEL_RAS    = 3'd3,
    SEL_TRAP   = 3'd4
  } pc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int unsigned DEFAULT_STEP         = 32'd4;
  localparam int          DEFAULT_RAS_DEPTH    = 4;

  // STEP is a power of two, so the low log2(STEP) bits are simply STEP-1.
  function automatic logic [63:0] align_mask(input logic [63:0] step);
    return step - 64'd1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest
// entry, and push+pop in one cycle rewrites the top entry in place.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [XLEN-1:0]  mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, top_inc_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok_s;

  assign pop_ok_s  = pop && (cnt_q != {CNT_W{1'b0}});
  assign top_inc_s = top_q + {{(PTR_W-1){1'b0}}, 1'b1};

  // Next stack state; the pointer wraps naturally because the depth is a power of two.
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    if (push && pop_ok_s) begin
      mem_d[top_q] = push_data;
    end else if (push) begin
      mem_d[top_inc_s] = push_data;
      top_d            = top_inc_s;
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_ok_s) begin
      top_d = top_q - {{(PTR_W-1){1'b0}}, 1'b1};
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      top_d = top_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= {XLEN{1'b0}};
      end
      top_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      mem_q <= mem_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  assign top_data = mem_q[top_q];
  assign empty    = (cnt_q == {CNT_W{1'b0}});
  assign full     = (cnt_q == CNT_FULL);

endmodule

// File: rtl/pc_unit.sv
// Program counter with trap > redirect > stall > sequential priority,
// return-address prediction and misaligned-target detection.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned     STEP         = DEFAULT_STEP,
  parameter int              RAS_DEPTH    = DEFAULT_RAS_DEPTH
) (
  input  logic            pc_clk,
  input  logic            pc_rst_n,
  input  logic            pc_stall,
  input  logic            pc_redirect,
  input  logic [XLEN-1:0] pc_target,
  input  logic            pc_call,
  input  logic            pc_ret,
  input  logic            pc_trap,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq,
  output logic            pc_ras_empty,
  output logic            pc_ras_full,
  output logic            pc_misaligned
);

  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(64'(STEP)));

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;
  pc_sel_e         sel_s;
  logic            push_s, pop_s, ras_hit_s, tgt_misaligned_s;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_empty_s, ras_full_s;

  assign pc_seq           = pc_q + STEP_INC;
  assign ras_hit_s        = pc_ret && !ras_empty_s;
  // A predicted return ignores pc_target entirely, including its alignment.
  assign tgt_misaligned_s = !ras_hit_s && ((pc_target & ALIGN_MASK) != {XLEN{1'b0}});

  // Next-PC source selection and stack control under fixed priority.
  always_comb begin
    sel_s        = SEL_SEQ;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    misaligned_d = 1'b0;
    if (pc_trap) begin
      sel_s = SEL_TRAP;
    end else if (pc_redirect) begin
      if (tgt_misaligned_s) begin
        sel_s        = SEL_TRAP;
        misaligned_d = 1'b1;
      end else begin
        if (ras_hit_s) begin
          sel_s = SEL_RAS;
          pop_s = 1'b1;
        end else begin
          sel_s = SEL_TARGET;
        end
        push_s = pc_call;
      end
    end else if (pc_stall) begin
      sel_s = SEL_HOLD;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_q;
    case (sel_s)
      SEL_SEQ:    pc_d = pc_seq;
      SEL_HOLD:   pc_d = pc_q;
      SEL_TARGET: pc_d = pc_target;
      SEL_RAS:    pc_d = ras_top_s;
      SEL_TRAP:   pc_d = TRAP_VECTOR;
      default:    pc_d = TRAP_VECTOR;
    endcase
  end

  always_ff @(posedge pc_clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (pc_clk),
    .rst_n     (pc_rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_seq),
    .top_data  (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_s)
  );

  assign pc_out        = pc_q;
  assign pc_ras_empty  = ras_empty_s;
  assign pc_ras_full   = ras_full_s;
  assign pc_misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps queue expected outputs,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, redirect, call, ret, trap;
  logic [31:0] target;
  logic [31:0] pc_out, pc_seq;
  logic        ras_empty, ras_full, misaligned;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        ful;
  } exp_t;

  exp_t sb[$];

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .STEP         (4),
    .RAS_DEPTH    (4)
  ) dut (
    .pc_clk        (clk),
    .pc_rst_n      (rst_n),
    .pc_stall      (stall),
    .pc_redirect   (redirect),
    .pc_target     (target),
    .pc_call       (call),
    .pc_ret        (ret),
    .pc_trap       (trap),
    .pc_out        (pc_out),
    .pc_seq        (pc_seq),
    .pc_ras_empty  (ras_empty),
    .pc_ras_full   (ras_full),
    .pc_misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every expectation on the cycle it falls due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s: expectation stale (due %0d, now %0d)", e.name, e.due, cyc);
      end else begin
        chk({e.name, ".pc"},    pc_out, e.pc);
        chk({e.name, ".seq"},   pc_seq, e.pc + 32'd4);
        chk({e.name, ".mis"},   {31'd0, misaligned}, {31'd0, e.mis});
        chk({e.name, ".empty"}, {31'd0, ras_empty},  {31'd0, e.emp});
        chk({e.name, ".full"},  {31'd0, ras_full},   {31'd0, e.ful});
      end
    end
  end

  // Called at a negedge: drive one cycle of inputs and queue the post-edge result.
  task automatic step(input string nm, input logic st, input logic rd, input logic [31:0] tg,
                      input logic cl, input logic rt, input logic tp,
                      input logic [31:0] epc, input logic emis, input logic eemp, input logic eful);
    exp_t e;
    stall = st; redirect = rd; target = tg; call = cl; ret = rt; trap = tp;
    e.due = cyc + 1; e.name = nm; e.pc = epc; e.mis = emis; e.emp = eemp; e.ful = eful;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; target = 32'd0; call = 1'b0; ret = 1'b0; trap = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst.pc",    pc_out, 32'h0);
    chk("rst.seq",   pc_seq, 32'h4);
    chk("rst.empty", {31'd0, ras_empty},  32'd1);
    chk("rst.full",  {31'd0, ras_full},   32'd0);
    chk("rst.mis",   {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   name         st    rd    target         cl    rt    tp    exp pc         mis   emp   ful
    step("run1",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
    step("run2",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
    step("run3",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 1'b1, 1'b0);

    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("async_rst.pc",    pc_out, 32'h0);
    chk("async_rst.empty", {31'd0, ras_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    step("seq4",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
    step("seq8",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 1'b0);
    step("seqC",      1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 1'b1, 1'b0);
    step("seq10",     1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
    step("stall1",    1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
    step("stall2",    1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
    step("unstall",   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0014, 1'b0, 1'b1, 1'b0);
    step("stall_rd",  1'b1, 1'b1, 32'h40,        1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
    step("jmp20",     1'b0, 1'b1, 32'h20,        1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b1, 1'b0);
    step("call200",   1'b0, 1'b1, 32'h200,       1'b1, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    step("ret999",    1'b0, 1'b1, 32'h999,       1'b0, 1'b1, 1'b0, 32'h0000_0024, 1'b0, 1'b1, 1'b0);
    step("call300",   1'b0, 1'b1, 32'h300,       1'b1, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    step("call400",   1'b0, 1'b1, 32'h400,       1'b1, 1'b0, 1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0);
    step("call500",   1'b0, 1'b1, 32'h500,       1'b1, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 1'b0);
    step("call600",   1'b0, 1'b1, 32'h600,       1'b1, 1'b0, 1'b0, 32'h0000_0600, 1'b0, 1'b0, 1'b1);
    step("call700",   1'b0, 1'b1, 32'h700,       1'b1, 1'b0, 1'b0, 32'h0000_0700, 1'b0, 1'b0, 1'b1);
    step("ret1",      1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0000_0604, 1'b0, 1'b0, 1'b0);
    step("ret2",      1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0000_0504, 1'b0, 1'b0, 1'b0);
    step("ret3",      1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0000_0404, 1'b0, 1'b0, 1'b0);
    step("ret4",      1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0000_0304, 1'b0, 1'b1, 1'b0);
    step("ret5_empty",1'b0, 1'b1, 32'h80,        1'b0, 1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1'b0);
    step("call800",   1'b0, 1'b1, 32'h800,       1'b1, 1'b0, 1'b0, 32'h0000_0800, 1'b0, 1'b0, 1'b0);
    step("misalign",  1'b0, 1'b1, 32'h102,       1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0);
    step("mis_clear", 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 1'b0);
    step("trap_call", 1'b0, 1'b1, 32'h900,       1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    step("ret_84",    1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0084, 1'b0, 1'b1, 1'b0);
    step("cr_no_rd",  1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0088, 1'b0, 1'b1, 1'b0);
    step("callA00",   1'b0, 1'b1, 32'hA00,       1'b1, 1'b0, 1'b0, 32'h0000_0A00, 1'b0, 1'b0, 1'b0);
    step("call_ret",  1'b0, 1'b1, 32'hB00,       1'b1, 1'b1, 1'b0, 32'h0000_008C, 1'b0, 1'b0, 1'b0);
    step("ret_A04",   1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0A04, 1'b0, 1'b1, 1'b0);
    step("jmp_top",   1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0);
    step("wrap1",     1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    step("wrap2",     1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    idle_inputs();
    #3;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
